contador_modn: RTL and testbench
================================

# contador_modn

Parametrised modulo-N counter digit: successor to the fixed mod-6 counter, generalised in modulus and width, with up/down direction, one-shot (saturating) mode, a cascade carry chain and clamped parallel load. Used as one digit of the clock/timer datapath; digits are chained `cout` → `cin` to build multi-digit minute/second/hour counters that count up or down.

## Interface

**Parameters**
- `MODULO`, default 6: number of states. Count range is 0..MODULO-1. Legal values are MODULO ≥ 2.
- `WIDTH`, default 3: width of `data` and `count`. Must satisfy 2^WIDTH ≥ MODULO.
- `ONE_SHOT`, default 0: 0 wraps at the terminal value; 1 holds at the terminal value.

**Ports**
- `clk` input, 1 bit: single clock, rising-edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `data` input, WIDTH bits: parallel load value.
- `load` input, 1 bit: synchronous load strobe, active-high.
- `enable` input, 1 bit: local count enable, active-high.
- `cin` input, 1 bit: cascade enable from the lower digit. Tie to 1 on the least-significant digit.
- `dir` input, 1 bit: 1 counts up, 0 counts down.
- `count` output, WIDTH bits: current value.
- `tc` output, 1 bit: terminal count flag.
- `cout` output, 1 bit: cascade carry/borrow to the next digit.

## Operation

- **Registered state:** `count` is the only state register.
- **Reset:** `reset`=0 forces `count`=0 immediately, independent of `clk`.
  - While in reset, `tc` equals `~dir`, so `tc`=1 after reset in down mode and 0 in up mode.
  - `cout` = `tc & enable & cin`.
- **Priority each rising edge:** reset > load > step > hold.
- **Load:**
  - `load`=1 sets `count` ← `data` when `data` < MODULO.
  - When `data` ≥ MODULO, `count` ← MODULO-1 (clamp).
  - Load ignores `enable`, `cin`, `dir` and `ONE_SHOT`.
- **Step:** occurs when `load`=0, `enable`=1 and `cin`=1.
  - Up, not terminal: `count`+1.
  - Up, at MODULO-1: ONE_SHOT=0 gives 0; ONE_SHOT=1 holds at MODULO-1.
  - Down, not terminal: `count`-1.
  - Down, at 0: ONE_SHOT=0 gives MODULO-1; ONE_SHOT=1 holds at 0.
- **Hold:** otherwise `count` keeps its value.
- **tc (combinational):** `tc` = (`dir`=1 and `count`=MODULO-1) or (`dir`=0 and `count`=0).
- **cout (combinational):** `cout` = `tc & enable & cin`.
  - Asserted for exactly the one cycle in which this digit wraps, so the next digit steps on the same edge.
  - In ONE_SHOT mode `cout` stays high while parked at terminal with enable and cin high. A downstream one-shot digit is expected to be used with its own terminal logic.
- **Direction change:** `dir` may change at any time. `tc`/`cout` re-evaluate combinationally and the next step follows the new direction. No extra state is kept.
- **Out-of-range state:** unreachable by construction (load clamps). If forced, the next step up goes to 0 and the next step down goes to MODULO-1.
- **Arithmetic:** all comparisons and increments are unsigned, WIDTH bits, with no overflow beyond MODULO-1.

## Timing

- `count` latency: 1 cycle from a sampled `load`/`enable`/`cin` to the updated `count`.
- `tc` and `cout` have zero latency from `count`, `dir`, `enable` and `cin`. They are combinational and must settle within one cycle through an N-digit chain.
- **Reset assertion mid-operation:** `count`=0 within the same cycle, with no clock needed.
- **Reset release:** the first step can occur on the first rising edge after `reset` goes high. The release must meet recovery time relative to `clk`.
- **Simultaneous load and step:** load wins. The step is lost and `cout` is still evaluated from the pre-edge `count`.

## Test plan

1. **Reset in down mode.** Hold `reset`=0 with `dir`=0, then release.
   - Required: `count`=0, `tc`=1, `cout`=`enable&cin`.
   - Assert `reset`=0 mid-count at `count`=4: `count`=0 before the next edge.
2. **Up wrap.** MODULO=6, ONE_SHOT=0, `dir`=1, `enable`=`cin`=1 for 13 edges from 0.
   - Required sequence: 0,1,2,3,4,5,0,1,...
   - `tc`=`cout`=1 only while `count`=5, i.e. 2 pulses.
3. **Down wrap and one-shot.** MODULO=10, `dir`=0, load 2.
   - ONE_SHOT=0: sequence 2,1,0,9,8.
   - ONE_SHOT=1: sequence 2,1,0,0,0, with `tc` steady at 1.
4. **Load clamp and priority.** MODULO=6.
   - Load `data`=7: `count`=5.
   - Load `data`=3 with `enable`=`cin`=1 on the same edge: `count`=3, not 4.
5. **Cascade.** Two digits, MODULO=10 and MODULO=6, up, units `cout` driving tens `cin`, 60 edges from 00.
   - Tens increment only on the units 9→0 edge.
   - After 59 the pair reads 00 and the tens `cout` pulses once.
6. **Gating.** With `enable`=0 or `cin`=0 for 5 edges: `count` unchanged and `cout`=0. Toggle `dir` at `count`=3: next step goes to 2.

Source files
------------

// File: rtl/contador_modn_if.sv
// Bus bundle for one contador_modn digit: load/count controls in, value and
// terminal/cascade flags out. clk and reset stay as plain module ports.
interface contador_modn_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             enable;
  logic             cin;
  logic             dir;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             cout;

  modport master (
    output data, load, enable, cin, dir,
    input  count, tc, cout
  );

  modport slave (
    input  data, load, enable, cin, dir,
    output count, tc, cout
  );
endinterface

// File: rtl/contador_modn.sv
// contador_modn: one modulo-N digit of the clock/timer datapath.
// Counts up or down, wraps or parks at the terminal value (ONE_SHOT),
// loads in parallel with clamping to MODULO-1, and chains cout -> cin
// so multi-digit counters step on the same edge as the lower digit wraps.
module contador_modn #(
  parameter int MODULO   = 6,
  parameter int WIDTH    = 3,
  parameter int ONE_SHOT = 0
) (
  input  logic            clk,
  input  logic            reset,
  contador_modn_if.slave  bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_up;
  logic [WIDTH-1:0] step_dn;
  logic [WIDTH-1:0] load_val;
  logic             tc;

  // Successor values for both directions; out-of-range states recover to the
  // natural wrap target so a forced bad value never sticks.
  always_comb begin
    step_up = count_q + ONE;
    if (count_q == LAST) begin
      step_up = (ONE_SHOT != 0) ? LAST : ZERO;
    end else if (count_q > LAST) begin
      step_up = ZERO;
    end

    step_dn = count_q - ONE;
    if (count_q == ZERO) begin
      step_dn = (ONE_SHOT != 0) ? ZERO : LAST;
    end else if (count_q > LAST) begin
      step_dn = LAST;
    end
  end

  // Next-state selection: load beats step, step needs both enable and cin.
  always_comb begin
    load_val = (bus.data > LAST) ? LAST : bus.data;
    count_d  = count_q;
    if (bus.load) begin
      count_d = load_val;
    end else if (bus.enable && bus.cin) begin
      count_d = bus.dir ? step_up : step_dn;
    end
  end

  // The count register is the only state in the digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal flag depends on the current direction, so a dir change
  // re-evaluates tc/cout immediately without extra state.
  always_comb begin
    tc = bus.dir ? (count_q == LAST) : (count_q == ZERO);
  end

  assign bus.count = count_q;
  assign bus.tc    = tc;
  assign bus.cout  = tc & bus.enable & bus.cin;

endmodule

// File: tb/tb_contador_modn.sv
// Bench for contador_modn: three standalone digits (mod-6 wrap, mod-10 wrap,
// mod-10 one-shot) share one stimulus stream; a mod-10/mod-6 pair is chained
// as a 0..59 counter. A plain-integer model tracks every digit.
module tb_contador_modn;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  contador_modn_if #(.WIDTH(3)) b6 ();
  contador_modn_if #(.WIDTH(4)) b10 ();
  contador_modn_if #(.WIDTH(4)) b10s ();
  contador_modn_if #(.WIDTH(4)) bu ();
  contador_modn_if #(.WIDTH(3)) bt ();

  contador_modn #(.MODULO(6),  .WIDTH(3), .ONE_SHOT(0)) u6   (.clk(clk), .reset(reset), .bus(b6));
  contador_modn #(.MODULO(10), .WIDTH(4), .ONE_SHOT(0)) u10  (.clk(clk), .reset(reset), .bus(b10));
  contador_modn #(.MODULO(10), .WIDTH(4), .ONE_SHOT(1)) u10s (.clk(clk), .reset(reset), .bus(b10s));
  contador_modn #(.MODULO(10), .WIDTH(4), .ONE_SHOT(0)) uu   (.clk(clk), .reset(reset), .bus(bu));
  contador_modn #(.MODULO(6),  .WIDTH(3), .ONE_SHOT(0)) ut   (.clk(clk), .reset(reset), .bus(bt));

  assign bt.cin = bu.cout;

  // shared stimulus for the standalone digits, separate enable for the pair
  logic       ld, en, ci, dr, cen;
  logic [3:0] dat;

  // reference state: plain integers
  int m6, m10, m10s, mc;
  int n_vec = 0;
  int n_err = 0;
  int p6, pt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nxt(input int m, input int os, input int cur, input int dval);
    if (ld) return (dval < m) ? dval : m - 1;
    if (!(en && ci)) return cur;
    if (dr) return (os != 0 && cur == m - 1) ? cur : (cur + 1) % m;
    return (os != 0 && cur == 0) ? 0 : (cur + m - 1) % m;
  endfunction

  function automatic bit tcm(input int m, input int cur);
    return dr ? (cur == m - 1) : (cur == 0);
  endfunction

  task automatic drive();
    b6.load = ld;   b6.data = dat[2:0]; b6.enable = en;   b6.cin = ci;   b6.dir = dr;
    b10.load = ld;  b10.data = dat;     b10.enable = en;  b10.cin = ci;  b10.dir = dr;
    b10s.load = ld; b10s.data = dat;    b10s.enable = en; b10s.cin = ci; b10s.dir = dr;
    bu.load = 1'b0; bu.data = '0; bu.enable = cen; bu.cin = 1'b1; bu.dir = 1'b1;
    bt.load = 1'b0; bt.data = '0; bt.enable = cen; bt.dir = 1'b1;
  endtask

  task automatic check_flags();
    chk("tc6",     b6.tc,     tcm(6, m6));
    chk("cout6",   b6.cout,   tcm(6, m6) && en && ci);
    chk("tc10",    b10.tc,    tcm(10, m10));
    chk("cout10",  b10.cout,  tcm(10, m10) && en && ci);
    chk("tc10s",   b10s.tc,   tcm(10, m10s));
    chk("cout10s", b10s.cout, tcm(10, m10s) && en && ci);
    chk("cout_u",  bu.cout,   (mc % 10 == 9) && cen);
    chk("cout_t",  bt.cout,   (mc == 59) && cen);
  endtask

  // called in the low clock phase; applies inputs, checks flags, clocks once
  task automatic cycle();
    drive();
    #1;
    check_flags();
    if (b6.cout) p6++;
    if (bt.cout) pt++;
    @(posedge clk);
    m6   = nxt(6, 0, m6, int'(dat[2:0]));
    m10  = nxt(10, 0, m10, int'(dat));
    m10s = nxt(10, 1, m10s, int'(dat));
    if (cen) mc = (mc + 1) % 60;
    @(negedge clk);
    chk("cnt6",   b6.count,   m6);
    chk("cnt10",  b10.count,  m10);
    chk("cnt10s", b10s.count, m10s);
    chk("units",  bu.count,   mc % 10);
    chk("tens",   bt.count,   mc / 10);
  endtask

  // asynchronous reset: counts must clear without a clock edge
  task automatic do_reset();
    reset = 1'b0;
    drive();
    #1;
    m6 = 0; m10 = 0; m10s = 0; mc = 0;
    chk("rst_cnt6",  b6.count,  0);
    chk("rst_cnt10", b10.count, 0);
    chk("rst_units", bu.count,  0);
    chk("rst_tens",  bt.count,  0);
    chk("rst_tc6",   b6.tc,     !dr);
    check_flags();
    @(negedge clk);
    reset = 1'b1;
  endtask

  int hold6;

  initial begin
    ld = 0; en = 1; ci = 1; dr = 0; cen = 1; dat = '0;
    p6 = 0; pt = 0;
    // reset in down mode: tc=1, cout=enable&cin
    do_reset();
    chk("rst_cout6", b6.cout, 1);

    // up wrap, 13 edges from 0
    dr = 1; p6 = 0;
    for (int i = 0; i < 13; i++) cycle();
    chk("wrap_end", b6.count, 1);
    chk("wrap_pulses", p6, 2);

    // down wrap vs one-shot from 2
    dr = 0; ld = 1; dat = 4'd2;
    cycle();
    ld = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("down_wrap", b10.count, 8);
    chk("down_os", b10s.count, 0);
    chk("down_os_tc", b10s.tc, 1);

    // load clamp, then load beating a same-edge step
    ld = 1; dat = 4'd7;
    cycle();
    chk("clamp6", b6.count, 5);
    dat = 4'd15;
    cycle();
    chk("clamp10", b10.count, 9);
    dat = 4'd3; dr = 1; en = 1; ci = 1;
    cycle();
    chk("ld_prio", b6.count, 3);

    // reset mid-count at 4
    dat = 4'd4;
    cycle();
    ld = 0;
    chk("pre_rst", b6.count, 4);
    do_reset();

    // cascade: 60 edges from 00
    dr = 1; cen = 1; pt = 0;
    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom_range(1));
      cycle();
    end
    chk("casc_units", bu.count, 0);
    chk("casc_tens", bt.count, 0);
    chk("casc_pulse", pt, 1);

    // gating: enable low then cin low
    ld = 1; dat = 4'd3; dr = 1; en = 1; ci = 1;
    cycle();
    ld = 0; hold6 = int'(b6.count);
    en = 0;
    for (int i = 0; i < 5; i++) cycle();
    en = 1; ci = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("gate_hold", b6.count, hold6);
    chk("gate_cout", b6.cout, 0);
    ci = 1; dr = 0;
    cycle();
    chk("dir_flip", b6.count, 2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(7) == 0);
      en  = ($urandom_range(3) != 0);
      ci  = ($urandom_range(3) != 0);
      dr  = 1'($urandom_range(1));
      cen = 1'($urandom_range(1));
      dat = 4'($urandom_range(15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
